// File: rtl/johnson_pkg.sv
// johnson_pkg: shared types and helper functions for the Johnson decoder/checker.
//   state_t        : lock FSM states (HUNT, ACQ, LOCKED)
//   decode_t       : {legal, idx} result of johnson_decode
//   johnson_encode : phase index -> Johnson codeword
//   johnson_decode : Johnson codeword -> {legal, idx}
//   next_index     : expected successor index, wrapping at 2*width
package johnson_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [7:0] idx;
    } decode_t;

    // Index k < width fills the k+1 LSBs with ones; index width+j clears the
    // j+1 LSBs of an all-ones word.
    function automatic logic [31:0] johnson_encode(input int idx, input int width);
        logic [63:0] ones_w;
        logic [63:0] low_mask;
        ones_w = (64'd1 << width) - 64'd1;
        if (idx < width) begin
            low_mask = (64'd1 << (idx + 1)) - 64'd1;
            return low_mask[31:0];
        end else begin
            low_mask = (64'd1 << (idx - width + 1)) - 64'd1;
            ones_w   = ones_w & ~low_mask;
            return ones_w[31:0];
        end
    endfunction

    function automatic decode_t johnson_decode(input logic [31:0] code, input int width);
        decode_t res;
        res.legal = 1'b0;
        res.idx   = 8'd0;
        for (int i = 0; i < 2 * MAX_WIDTH; i++) begin
            if ((i < 2 * width) && (code == johnson_encode(i, width))) begin
                res.legal = 1'b1;
                res.idx   = 8'(i);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic int next_index(input int i, input int width);
        if (i >= 2 * width - 1) begin
            return 0;
        end else begin
            return i + 1;
        end
    endfunction

endpackage

// File: rtl/johnson_decoder_checker_decode.sv
// johnson_code_decode: combinational Johnson codeword decoder.
//   code  (in,  WIDTH)  candidate codeword
//   legal (out, 1)      code is one of the 2*WIDTH legal words
//   index (out, IDX_W)  phase index of code (0 when illegal)
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] code,
    output logic             legal,
    output logic [IDX_W-1:0] index
);

    // Compare against every legal word; at most one can match.
    always_comb begin
        legal = 1'b0;
        index = {IDX_W{1'b0}};
        for (int i = 0; i < 2 * WIDTH; i++) begin
            if (code == WIDTH'(johnson_encode(i, WIDTH))) begin
                legal = 1'b1;
                index = IDX_W'(i);
            end else begin
                legal = legal;
            end
        end
    end

endmodule

// File: rtl/johnson_decoder_checker.sv
// johnson_decoder_checker: decodes a Johnson codeword stream, flags illegal
// words and out-of-sequence steps, tracks sequence lock and counts errors.
//   clk, rst (sync, active-high)
//   in_valid, in_code[WIDTH]   sampled codeword
//   err_clr                    synchronous clear of err_count
//   out_valid, out_index       registered decode result
//   code_illegal, seq_error    one-cycle error pulses (mutually exclusive)
//   locked                     sequence lock status
//   err_count[ERR_CNT_W]       saturating error counter
// All outputs are registered, one cycle after the input sample.
module johnson_decoder_checker
    import johnson_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_CNT_W  = 8,
    localparam int IDX_W     = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_code,
    input  logic                 err_clr,
    output logic                 out_valid,
    output logic [IDX_W-1:0]     out_index,
    output logic                 code_illegal,
    output logic                 seq_error,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [3:0]           LOCK_N  = 4'(LOCK_COUNT);

    logic                 dec_legal_s;
    logic [IDX_W-1:0]     dec_index_s;
    logic [IDX_W-1:0]     dec_next_s;

    state_t               state_r, state_s;
    logic [IDX_W-1:0]     expected_r, expected_s;
    logic [3:0]           good_cnt_r, good_cnt_s;
    logic                 out_valid_r;
    logic [IDX_W-1:0]     out_index_r, out_index_s;
    logic                 code_illegal_r, code_illegal_s;
    logic                 seq_error_r, seq_error_s;
    logic                 locked_r, locked_s;
    logic [ERR_CNT_W-1:0] err_count_r, err_count_s;

    johnson_code_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .code  (in_code),
        .legal (dec_legal_s),
        .index (dec_index_s)
    );

    assign dec_next_s = IDX_W'(next_index(int'(dec_index_s), WIDTH));

    // Lock FSM next state and next output values.
    always_comb begin
        state_s        = state_r;
        expected_s     = expected_r;
        good_cnt_s     = good_cnt_r;
        out_index_s    = out_index_r;
        code_illegal_s = 1'b0;
        seq_error_s    = 1'b0;
        locked_s       = locked_r;
        if (in_valid) begin
            if (!dec_legal_s) begin
                out_index_s    = {IDX_W{1'b0}};
                code_illegal_s = 1'b1;
                state_s        = HUNT;
                good_cnt_s     = 4'd0;
                locked_s       = 1'b0;
            end else begin
                out_index_s = dec_index_s;
                // Every legal sample either advances or re-seeds, so the
                // successor of this sample is always the next expectation.
                expected_s  = dec_next_s;
                case (state_r)
                    HUNT: begin
                        good_cnt_s = 4'd1;
                        state_s    = ACQ;
                        locked_s   = 1'b0;
                    end
                    ACQ: begin
                        if (dec_index_s == expected_r) begin
                            good_cnt_s = good_cnt_r + 4'd1;
                            if ((good_cnt_r + 4'd1) >= LOCK_N) begin
                                state_s  = LOCKED;
                                locked_s = 1'b1;
                            end else begin
                                locked_s = 1'b0;
                            end
                        end else begin
                            good_cnt_s = 4'd1;
                            locked_s   = 1'b0;
                        end
                    end
                    LOCKED: begin
                        if (dec_index_s == expected_r) begin
                            locked_s = 1'b1;
                        end else begin
                            seq_error_s = 1'b1;
                            locked_s    = 1'b0;
                            good_cnt_s  = 4'd1;
                            state_s     = ACQ;
                        end
                    end
                    default: begin
                        state_s    = HUNT;
                        good_cnt_s = 4'd0;
                        locked_s   = 1'b0;
                    end
                endcase
            end
        end else begin
            out_index_s = out_index_r;
        end
    end

    // Saturating error counter; an error on the clearing cycle leaves 1.
    always_comb begin
        err_count_s = err_count_r;
        if (code_illegal_s || seq_error_s) begin
            if (err_clr) begin
                err_count_s = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else if (err_count_r == ERR_MAX) begin
                err_count_s = ERR_MAX;
            end else begin
                err_count_s = err_count_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (err_clr) begin
            err_count_s = {ERR_CNT_W{1'b0}};
        end else begin
            err_count_s = err_count_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= HUNT;
            expected_r     <= {IDX_W{1'b0}};
            good_cnt_r     <= 4'd0;
            out_valid_r    <= 1'b0;
            out_index_r    <= {IDX_W{1'b0}};
            code_illegal_r <= 1'b0;
            seq_error_r    <= 1'b0;
            locked_r       <= 1'b0;
            err_count_r    <= {ERR_CNT_W{1'b0}};
        end else begin
            state_r        <= state_s;
            expected_r     <= expected_s;
            good_cnt_r     <= good_cnt_s;
            out_valid_r    <= in_valid;
            out_index_r    <= out_index_s;
            code_illegal_r <= code_illegal_s;
            seq_error_r    <= seq_error_s;
            locked_r       <= locked_s;
            err_count_r    <= err_count_s;
        end
    end

    assign out_valid    = out_valid_r;
    assign out_index    = out_index_r;
    assign code_illegal = code_illegal_r;
    assign seq_error    = seq_error_r;
    assign locked       = locked_r;
    assign err_count    = err_count_r;

endmodule
